uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding single bytes from N_REQ requesters into one UART
// transmitter; a requester keeps ownership until the last byte of its packet or a lock timeout.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [8*N_REQ-1:0]       req_data_i,
  input  logic [N_REQ-1:0]         req_last_i,
  output logic [N_REQ-1:0]         req_ack_o,
  output logic [7:0]               tx_data_o,
  output logic                     tx_ready_o,
  input  logic                     tx_ack_i,
  output logic [$clog2(N_REQ)-1:0] grant_o,
  output logic                     busy_o,
  output logic                     timeout_o
);

  localparam int unsigned GW = $clog2(N_REQ);
  localparam int unsigned TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST = (LOCK_TIMEOUT > 0) ? TW'(LOCK_TIMEOUT - 1) : '0;
  localparam logic [TW-1:0] T_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SEND, LOCKED} state_t;

  state_t            state, state_d;
  logic [GW-1:0]     ptr, ptr_d, grant_d, rr_idx;
  logic              rr_hit;
  logic [7:0]        hold_data, hold_data_d;
  logic              hold_last, hold_last_d;
  logic [TW-1:0]     timer, timer_d;
  logic [N_REQ-1:0]  ack_d;
  logic              timeout_d;
  logic [1:0]        rst_sync;
  logic              rst_n;

  // Reset asserts asynchronously but is released two clock edges later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Search starts just after the previous packet owner, which is checked last.
  always_comb begin
    int unsigned cand;
    rr_hit = 1'b0;
    rr_idx = ptr;
    cand   = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(ptr) + k) % N_REQ;
      if (!rr_hit && req_valid_i[GW'(cand)]) begin
        rr_hit = 1'b1;
        rr_idx = GW'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    grant_d     = grant_o;
    hold_data_d = hold_data;
    hold_last_d = hold_last;
    timer_d     = timer;
    ack_d       = '0;
    timeout_d   = 1'b0;
    case (state)
      IDLE: begin
        if (rr_hit) begin
          state_d       = SEND;
          grant_d       = rr_idx;
          hold_data_d   = req_data_i[{rr_idx, 3'b000} +: 8];
          hold_last_d   = req_last_i[rr_idx];
          ack_d[rr_idx] = 1'b1;
        end
      end
      SEND: begin
        if (tx_ack_i) begin
          if (hold_last) begin
            state_d = IDLE;
            ptr_d   = grant_o;
          end else begin
            state_d = LOCKED;
            timer_d = '0;
          end
        end
      end
      LOCKED: begin
        if (req_valid_i[grant_o]) begin
          state_d        = SEND;
          hold_data_d    = req_data_i[{grant_o, 3'b000} +: 8];
          hold_last_d    = req_last_i[grant_o];
          ack_d[grant_o] = 1'b1;
          timer_d        = '0;
        end else if (LOCK_TIMEOUT != 0 && timer == T_LAST) begin
          state_d   = IDLE;
          ptr_d     = grant_o;
          timeout_d = 1'b1;
        end else if (timer != T_MAX) begin
          timer_d = timer + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= GW'(N_REQ - 1);
      grant_o   <= '0;
      hold_data <= '0;
      hold_last <= 1'b0;
      timer     <= '0;
      req_ack_o <= '0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      grant_o   <= grant_d;
      hold_data <= hold_data_d;
      hold_last <= hold_last_d;
      timer     <= timer_d;
      req_ack_o <= ack_d;
      timeout_o <= timeout_d;
    end
  end

  assign tx_data_o  = hold_data;
  assign tx_ready_o = (state == SEND);
  assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed vector bench for uart_tx_arbiter (N_REQ=4, LOCK_TIMEOUT=16):
// a per-cycle vector table plus hand sequences for stall, timeout and reset.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_last_i;
  logic [3:0]  req_ack_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_o;
  logic        tx_ack_i;
  logic [1:0]  grant_o;
  logic        busy_o;
  logic        timeout_o;

  uart_tx_arbiter #(.N_REQ(4), .LOCK_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ack_o(req_ack_o), .tx_data_o(tx_data_o), .tx_ready_o(tx_ready_o),
    .tx_ack_i(tx_ack_i), .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        txack;
    logic [16:0] exp;
  } vec_t;

  vec_t        vecs[19];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [7:0]  tx_log[$];
  logic [7:0]  exp_log[12];

  always @(posedge clk)
    if (tx_ready_o && tx_ack_i) tx_log.push_back(tx_data_o);

  function automatic logic [16:0] ex(input logic [3:0] ack, input logic [1:0] g,
                                     input logic rdy, input logic bsy, input logic tmo,
                                     input logic [7:0] d);
    return {ack, g, rdy, bsy, tmo, d};
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                              input logic ta, input logic [16:0] e);
    vec_t r;
    r.valid = v; r.last = l; r.data = d; r.txack = ta; r.exp = e;
    return r;
  endfunction

  task automatic check(input string name, input logic [16:0] exp);
    logic [16:0] got;
    got = {req_ack_o, grant_o, tx_ready_o, busy_o, timeout_o, tx_data_o};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {ack,grant,rdy,busy,tmo,data}=%h, want %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                       input logic ta);
    req_valid_i = v; req_last_i = l; req_data_i = d; tx_ack_i = ta;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Full rotation with every requester sending one-byte packets.
    for (int i = 0; i < 10; i += 2) begin
      logic [1:0] g;
      logic [3:0] oh;
      logic [7:0] d;
      g  = 2'(i / 2);
      oh = 4'b0001 << g;
      d  = 8'h11 * (8'(g) + 8'd1);
      vecs[i]   = mk(4'b1111, 4'b1111, 32'h44332211, 1'b1, ex(oh,    g, 1'b1, 1'b1, 1'b0, d));
      vecs[i+1] = mk(4'b1111, 4'b1111, 32'h44332211, 1'b1, ex(4'b0, g, 1'b0, 1'b0, 1'b0, d));
    end
    // Requester 1 sends a three-byte packet while requester 2 waits.
    vecs[10] = mk(4'b0110, 4'b0100, 32'h00991100, 1'b1, ex(4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 8'h11));
    vecs[11] = mk(4'b0110, 4'b0100, 32'h00991100, 1'b1, ex(4'b0000, 2'd1, 1'b0, 1'b1, 1'b0, 8'h11));
    vecs[12] = mk(4'b0110, 4'b0100, 32'h00992200, 1'b1, ex(4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 8'h22));
    vecs[13] = mk(4'b0110, 4'b0100, 32'h00992200, 1'b1, ex(4'b0000, 2'd1, 1'b0, 1'b1, 1'b0, 8'h22));
    vecs[14] = mk(4'b0110, 4'b0110, 32'h00993300, 1'b1, ex(4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 8'h33));
    vecs[15] = mk(4'b0110, 4'b0110, 32'h00993300, 1'b1, ex(4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 8'h33));
    vecs[16] = mk(4'b0100, 4'b0100, 32'h00990000, 1'b1, ex(4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 8'h99));
    vecs[17] = mk(4'b0100, 4'b0100, 32'h00990000, 1'b1, ex(4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 8'h99));
    vecs[18] = mk(4'b0000, 4'b0000, 32'h00000000, 1'b1, ex(4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 8'h99));
    exp_log = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h11, 8'h22, 8'h33, 8'h99,
                8'h5A, 8'hA1, 8'h11};

    reset_n = 1'b0;
    drive(4'b0, 4'b0, 32'h0, 1'b0);
    step; step;
    check("reset", '0);
    reset_n = 1'b1;
    step; step; step;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].txack);
      step;
      check($sformatf("row%0d", i), vecs[i].exp);
    end

    // Capture while the UART is busy, then a 50-cycle stall.
    drive(4'b1000, 4'b1000, 32'h5A000000, 1'b0);
    step; check("stall_cap", ex(4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 8'h5A));
    step; check("stall_hold", ex(4'b0000, 2'd3, 1'b1, 1'b1, 1'b0, 8'h5A));
    req_valid_i = 4'b0;
    for (int i = 0; i < 50; i++) begin
      step; check($sformatf("stall%0d", i), ex(4'b0000, 2'd3, 1'b1, 1'b1, 1'b0, 8'h5A));
    end
    tx_ack_i = 1'b1;
    step; check("stall_xfer", ex(4'b0000, 2'd3, 1'b0, 1'b0, 1'b0, 8'h5A));
    step; check("stall_once", ex(4'b0000, 2'd3, 1'b0, 1'b0, 1'b0, 8'h5A));

    // Owner 0 abandons its packet; requester 1 is ignored until the timeout.
    drive(4'b0011, 4'b0010, 32'h0000B2A1, 1'b1);
    step; check("to_cap", ex(4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 8'hA1));
    step; check("to_lock", ex(4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 8'hA1));
    req_valid_i = 4'b0010;
    for (int k = 1; k <= 15; k++) begin
      step; check($sformatf("lock%0d", k), ex(4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 8'hA1));
    end
    step; check("timeout", ex(4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 8'hA1));
    step; check("after_to", ex(4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 8'hB2));

    // Reset while holding an unsent byte.
    tx_ack_i = 1'b0;
    step; check("pre_rst", ex(4'b0000, 2'd1, 1'b1, 1'b1, 1'b0, 8'hB2));
    req_valid_i = 4'b0;
    #2 reset_n = 1'b0;
    #1 check("rst_async", '0);
    drive(4'b1111, 4'b1111, 32'h44332211, 1'b1);
    step; check("rst_held", '0);
    step;
    reset_n = 1'b1;
    step; check("rel_p1", '0);
    step; check("rel_p2", '0);
    step; check("rel_p3", ex(4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 8'h11));
    req_valid_i = 4'b0;
    step; check("rel_p4", ex(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 8'h11));
    step;

    n_vec++;
    if (tx_log.size() != 12) begin
      n_bad++;
      $display("FAIL log_len: got %0d transfers, want 12", tx_log.size());
    end
    for (int i = 0; i < 12 && i < tx_log.size(); i++) begin
      n_vec++;
      if (tx_log[i] !== exp_log[i]) begin
        n_bad++;
        $display("FAIL log%0d: got %h, want %h", i, tx_log[i], exp_log[i]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
